// File: rtl/sine_meas_pkg.sv
// Shared constants and types for the sine period/peak measurement block.
// Consumers pick these up with import sine_meas_pkg::*.
package sine_meas_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int CNT_W_DEF  = 16;

    localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MAX = 24'sh7FFFFF;
    localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MIN = 24'sh800000;

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } meas_state_t;

endpackage

// File: rtl/sine_measure_zero_cross.sv
// Rising zero-crossing detector with hysteresis arming.
// A crossing only counts after the signal has been below -HYST since the last crossing.
module zero_cross_detect #(
    parameter int DATA_W = 24,
    parameter int HYST   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              disarm,
    output logic              rise
);

    localparam logic signed [DATA_W-1:0] NEG_HYST = DATA_W'(-HYST);

    logic signed [DATA_W-1:0] sample_s;
    logic                     armed;
    logic                     below;

    assign sample_s = $signed(sample_in);
    assign below    = sample_s < NEG_HYST;
    assign rise     = sample_valid && armed && !sample_s[DATA_W-1];

    // A timeout abandons any half-seen cycle, so the arm is dropped with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (sample_valid) begin
            if (disarm)
                armed <= 1'b0;
            else if (below)
                armed <= 1'b1;
            else if (rise)
                armed <= 1'b0;
        end
    end

endmodule

// File: rtl/sine_measure.sv
// Per-cycle tone measurement: period, peaks, half peak-to-peak amplitude and lock.
// state | meaning: SEARCH = waiting for first armed rise; MEASURE = counting a period.
module sine_measure
    import sine_meas_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MAX_PERIOD = 4096,
    parameter int HYST       = 1024,
    parameter int PERIOD_TOL = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] peak_pos,
    output logic [DATA_W-1:0] peak_neg,
    output logic [DATA_W-1:0] amplitude,
    output logic              meas_valid,
    output logic              locked,
    output logic              timeout
);

    localparam int CONS_W = $clog2(LOCK_COUNT + 1);

    meas_state_t              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic signed [DATA_W-1:0] min_q, min_d;
    logic [CNT_W-1:0]         prev_q, prev_d;
    logic [CONS_W-1:0]        cons_q, cons_d;
    logic                     first_q, first_d;
    logic [CNT_W-1:0]         period_d;
    logic [DATA_W-1:0]        peak_pos_d, peak_neg_d, amplitude_d;
    logic                     meas_valid_d, locked_d, timeout_d;

    logic signed [DATA_W-1:0] sample_s;
    logic                     rise;
    logic [CNT_W-1:0]         diff;
    logic [DATA_W:0]          span;

    assign sample_s = $signed(sample_in);

    zero_cross_detect #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_zero_cross (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .disarm       (timeout_d),
        .rise         (rise)
    );

    assign diff = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
    // One extra bit so the full signed range difference cannot wrap.
    assign span = {max_q[DATA_W-1], max_q} - {min_q[DATA_W-1], min_q};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        min_d        = min_q;
        prev_d       = prev_q;
        cons_d       = cons_q;
        first_d      = first_q;
        period_d     = period;
        peak_pos_d   = peak_pos;
        peak_neg_d   = peak_neg;
        amplitude_d  = amplitude;
        locked_d     = locked;
        meas_valid_d = 1'b0;
        timeout_d    = 1'b0;

        if (sample_valid) begin
            case (state_q)
                SEARCH: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_W'(1);
                        max_d   = sample_s;
                        min_d   = sample_s;
                        first_d = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d     = cnt_q;
                        peak_pos_d   = max_q;
                        peak_neg_d   = min_q;
                        amplitude_d  = span[DATA_W:1];
                        meas_valid_d = 1'b1;
                        cnt_d        = CNT_W'(1);
                        max_d        = sample_s;
                        min_d        = sample_s;
                        prev_d       = cnt_q;
                        first_d      = 1'b0;
                        if (!first_q) begin
                            if (diff <= CNT_W'(PERIOD_TOL)) begin
                                if (cons_q < CONS_W'(LOCK_COUNT))
                                    cons_d = cons_q + CONS_W'(1);
                                if (cons_q >= CONS_W'(LOCK_COUNT - 1))
                                    locked_d = 1'b1;
                            end else begin
                                cons_d   = '0;
                                locked_d = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (sample_s > max_q)
                            max_d = sample_s;
                        if (sample_s < min_q)
                            min_d = sample_s;
                        if (cnt_q == CNT_W'(MAX_PERIOD)) begin
                            timeout_d = 1'b1;
                            locked_d  = 1'b0;
                            cons_d    = '0;
                            state_d   = SEARCH;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEARCH;
            cnt_q      <= '0;
            max_q      <= '0;
            min_q      <= '0;
            prev_q     <= '0;
            cons_q     <= '0;
            first_q    <= 1'b0;
            period     <= '0;
            peak_pos   <= '0;
            peak_neg   <= '0;
            amplitude  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            min_q      <= min_d;
            prev_q     <= prev_d;
            cons_q     <= cons_d;
            first_q    <= first_d;
            period     <= period_d;
            peak_pos   <= peak_pos_d;
            peak_neg   <= peak_neg_d;
            amplitude  <= amplitude_d;
            meas_valid <= meas_valid_d;
            locked     <= locked_d;
            timeout    <= timeout_d;
        end
    end

endmodule
